// File: rtl/lane_block_distributor_pkg.sv
// Shared PCS constants, FSM state encoding and block tagging helper.
package lane_block_distributor_pkg;

  localparam int unsigned LEN_CODED_BLOCK   = 66;
  localparam int unsigned LEN_TAGGED_BLOCK  = 67;
  localparam int unsigned N_LANES_DEFAULT   = 20;
  localparam int unsigned AM_PERIOD_DEFAULT = 16384;

  typedef enum logic {
    FILL    = 1'b0,
    EMIT_AM = 1'b1
  } state_t;

  typedef logic [LEN_CODED_BLOCK-1:0]  coded_block_t;
  typedef logic [LEN_TAGGED_BLOCK-1:0] tagged_block_t;

  // Prepend the AM tag bit to a coded block.
  function automatic tagged_block_t tag_block(input logic am_tag, input coded_block_t blk);
    return {am_tag, blk};
  endfunction

endpackage

// File: rtl/lane_block_distributor_if.sv
// Block-in / row-out handshake bundle of the lane block distributor.
interface lane_block_distributor_if
  import lane_block_distributor_pkg::*;
#(
  parameter int unsigned N_LANES = N_LANES_DEFAULT
) ();

  logic                                i_valid;
  coded_block_t                        i_data;
  logic                                o_ready;
  logic                                o_valid;
  logic [LEN_TAGGED_BLOCK*N_LANES-1:0] o_data;

  modport slave (
    input  i_valid,
    input  i_data,
    output o_ready,
    output o_valid,
    output o_data
  );

  modport master (
    output i_valid,
    output i_data,
    input  o_ready,
    input  o_valid,
    input  o_data
  );

endinterface

// File: rtl/lane_block_distributor_am_period_counter.sv
// Row counter within an AM period; am_due flags the last data row of the period.
module am_period_counter #(
  parameter int unsigned AM_PERIOD = lane_block_distributor_pkg::AM_PERIOD_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic load_one_i,
  input  logic incr_i,
  output logic am_due_o
);

  localparam int unsigned     CW   = $clog2(AM_PERIOD);
  localparam logic [CW-1:0]   LAST = CW'(AM_PERIOD - 1);

  logic [CW-1:0] frame_cnt_q, frame_cnt_d;

  // AM row restarts the count at 1; a completed data row advances it with explicit wrap.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (load_one_i) begin
      frame_cnt_d = CW'(1);
    end else if (incr_i) begin
      frame_cnt_d = (frame_cnt_q == LAST) ? '0 : frame_cnt_q + CW'(1);
    end
  end

  // Count register, frozen while disabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_cnt_q <= '0;
    end else if (en_i) begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign am_due_o = (frame_cnt_q == LAST);

endmodule

// File: rtl/lane_block_distributor.sv
// Round-robin distribution of 66b blocks into tagged N_LANES rows, with one
// AM-slot row (all tags set, zero payload) opening every AM period.
module lane_block_distributor
  import lane_block_distributor_pkg::*;
#(
  parameter int unsigned N_LANES   = N_LANES_DEFAULT,
  parameter int unsigned AM_PERIOD = AM_PERIOD_DEFAULT
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_enable,
  lane_block_distributor_if.slave  bus
);

  localparam int unsigned     LW        = $clog2(N_LANES);
  localparam int unsigned     ROW_W     = LEN_TAGGED_BLOCK * N_LANES;
  localparam logic [LW-1:0]   LAST_LANE = LW'(N_LANES - 1);

  state_t          state_q;
  logic [LW-1:0]   lane_idx_q;
  coded_block_t    row_q [N_LANES-1];
  logic            o_valid_q;
  logic [ROW_W-1:0] o_data_q;
  logic [ROW_W-1:0] data_row_d;
  logic [ROW_W-1:0] am_row_d;
  logic            fill;
  logic            accept;
  logic            row_done;
  logic            am_due;

  assign fill     = (state_q == FILL);
  assign accept   = i_enable & fill & bus.i_valid;
  assign row_done = accept & (lane_idx_q == LAST_LANE);

  assign bus.o_ready = i_enable & fill;
  // o_valid_q is frozen with the rest of the state while disabled, so masking
  // here keeps o_valid low during disabled cycles without losing a row pulse.
  assign bus.o_valid = o_valid_q & i_enable;
  assign bus.o_data  = o_data_q;

  // Assemble the outgoing data row (incoming block in the last lane) and the AM row.
  always_comb begin
    data_row_d = '0;
    am_row_d   = '0;
    for (int unsigned i = 0; i < N_LANES - 1; i++) begin
      data_row_d[(N_LANES-1-i)*LEN_TAGGED_BLOCK +: LEN_TAGGED_BLOCK] = tag_block(1'b0, row_q[i]);
    end
    data_row_d[0 +: LEN_TAGGED_BLOCK] = tag_block(1'b0, bus.i_data);
    for (int unsigned i = 0; i < N_LANES; i++) begin
      am_row_d[i*LEN_TAGGED_BLOCK +: LEN_TAGGED_BLOCK] = tag_block(1'b1, '0);
    end
  end

  // FSM with row buffer and registered outputs; everything holds while disabled.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= EMIT_AM;
      lane_idx_q <= '0;
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      for (int unsigned i = 0; i < N_LANES - 1; i++) begin
        row_q[i] <= '0;
      end
    end else if (i_enable) begin
      o_valid_q <= 1'b0;
      unique case (state_q)
        EMIT_AM: begin
          o_valid_q <= 1'b1;
          o_data_q  <= am_row_d;
          state_q   <= FILL;
        end
        FILL: begin
          if (bus.i_valid) begin
            if (lane_idx_q == LAST_LANE) begin
              o_valid_q  <= 1'b1;
              o_data_q   <= data_row_d;
              lane_idx_q <= '0;
              if (am_due) begin
                state_q <= EMIT_AM;
              end
            end else begin
              row_q[lane_idx_q] <= bus.i_data;
              lane_idx_q        <= lane_idx_q + LW'(1);
            end
          end
        end
        default: begin
          state_q <= EMIT_AM;
        end
      endcase
    end
  end

  am_period_counter #(
    .AM_PERIOD (AM_PERIOD)
  ) u_am_period_counter (
    .clk_i      (i_clock),
    .rst_i      (i_reset),
    .en_i       (i_enable),
    .load_one_i (state_q == EMIT_AM),
    .incr_i     (row_done),
    .am_due_o   (am_due)
  );

endmodule

// File: tb/tb_lane_block_distributor.sv
// Directed/random bench: DUT A (20 lanes, AM period 4) against a row model
// built from the handshake record; DUT B (2 lanes, AM period 16384) for AM spacing.
module tb_lane_block_distributor;
  import lane_block_distributor_pkg::*;

  localparam int unsigned NL  = 20;
  localparam int unsigned PA  = 4;
  localparam int unsigned NLB = 2;
  localparam int unsigned PB  = 16384;
  localparam int unsigned TB  = LEN_TAGGED_BLOCK;
  localparam int unsigned W   = TB * NL;

  logic clk = 1'b0;
  logic rst;
  logic en_a;
  logic en_b;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  coded_block_t  accq[$];
  int unsigned   rows_a;
  logic [W-1:0]  last_row;

  lane_block_distributor_if #(.N_LANES(NL))  ifa ();
  lane_block_distributor_if #(.N_LANES(NLB)) ifb ();

  lane_block_distributor #(.N_LANES(NL), .AM_PERIOD(PA)) dut_a (
    .i_clock (clk),
    .i_reset (rst),
    .i_enable(en_a),
    .bus     (ifa)
  );

  lane_block_distributor #(.N_LANES(NLB), .AM_PERIOD(PB)) dut_b (
    .i_clock (clk),
    .i_reset (rst),
    .i_enable(en_b),
    .bus     (ifb)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    int unsigned   lane;
    tagged_block_t ob, ex;
    lane = NL - 1;
    ob   = obs[TB-1:0];
    ex   = exp[TB-1:0];
    for (int i = 0; i < int'(NL); i++) begin
      if (obs[i*TB +: TB] !== exp[i*TB +: TB]) begin
        lane = NL - 1 - i;
        ob   = obs[i*TB +: TB];
        ex   = exp[i*TB +: TB];
      end
    end
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s lane %0d: observed %0h expected %0h", tag, lane, ob, ex);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    check(tag, W'(obs), W'(exp));
  endtask

  function automatic coded_block_t rnd_blk();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[65:0];
  endfunction

  // Expected row stream: row k after reset is an AM row iff k % PA == 0,
  // otherwise it carries the next 20 accepted blocks, lane0 first.
  task automatic monitor_a(input logic en, input logic rdy);
    logic [W-1:0] exp;
    logic         am;
    coded_block_t b;
    if (!en) begin
      chk_bit("valid_while_disabled", ifa.o_valid, 1'b0);
    end else begin
      if (!rdy) chk_bit("ready_low_then_am", ifa.o_valid, 1'b1);
      if (ifa.o_valid === 1'b1) begin
        am  = ((rows_a % PA) == 0);
        exp = '0;
        if (am) begin
          for (int i = 0; i < int'(NL); i++) exp = (exp << TB) | W'({1'b1, 66'd0});
          check("row", ifa.o_data, exp);
        end else if (accq.size() < NL) begin
          check("blocks_available", W'(accq.size()), W'(NL));
        end else begin
          for (int i = 0; i < int'(NL); i++) begin
            b   = accq.pop_front();
            exp = (exp << TB) | W'({1'b0, b});
          end
          check("row", ifa.o_data, exp);
        end
        chk_bit("am_iff_ready_low", rdy, !am);
        rows_a++;
        last_row = exp;
      end
    end
    if (ifa.o_valid !== 1'b1) check("data_hold", ifa.o_data, last_row);
  endtask

  // One clock of DUT A stimulus, entered and left at a negedge.
  task automatic cyc(input logic v, input coded_block_t d, input logic en, output logic acc);
    logic rdy;
    ifa.i_valid = v;
    ifa.i_data  = d;
    en_a        = en;
    #1 rdy = ifa.o_ready;
    if (!en) chk_bit("ready_while_disabled", rdy, 1'b0);
    @(posedge clk);
    acc = v && en && rdy;
    if (acc) accq.push_back(d);
    @(negedge clk);
    monitor_a(en, rdy);
  endtask

  task automatic send(input coded_block_t d, input bit gaps);
    logic        acc, v, e;
    int unsigned n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      e = gaps ? ($urandom_range(0, 4) != 0) : 1'b1;
      cyc(v, d, e, acc);
      n++;
    end
    if (!acc) chk_bit("accept_timeout", acc, 1'b1);
  endtask

  task automatic apply_reset();
    ifa.i_valid = 1'b0;
    en_a        = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_bit("rst_o_valid", ifa.o_valid, 1'b0);
    chk_bit("rst_o_ready", ifa.o_ready, 1'b0);
    check("rst_o_data", ifa.o_data, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    accq.delete();
    rows_a   = 0;
    last_row = '0;
  endtask

  initial begin
    logic        acc;
    logic        am;
    int unsigned rb;
    int unsigned n;

    rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
    ifa.i_valid = 1'b0; ifa.i_data = '0;
    ifb.i_valid = 1'b0; ifb.i_data = '0;
    rows_a = 0; last_row = '0;
    #3;
    chk_bit("init_o_valid", ifa.o_valid, 1'b0);
    chk_bit("init_o_ready", ifa.o_ready, 1'b0);
    check("init_o_data", ifa.o_data, '0);
    chk_bit("init_b_o_valid", ifb.o_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // First row after reset is the AM row; o_ready low in that slot.
    cyc(1'b0, '0, 1'b1, acc);
    chk_bit("first_row_valid", ifa.o_valid, 1'b1);

    // Blocks 0..19 back-to-back, row one cycle after the last accept.
    for (int i = 0; i < 20; i++) send(66'(i), 1'b0);
    chk_bit("row_latency", ifa.o_valid, 1'b1);
    check("lane0_block0", W'(ifa.o_data[W-1 -: TB]), W'(67'd0));
    check("lane19_block19", W'(ifa.o_data[TB-1:0]), W'(67'd19));

    // Continuous random stream across two AM periods.
    for (int i = 0; i < 140; i++) send(rnd_blk(), 1'b0);

    // Random i_valid gaps and i_enable low pulses.
    for (int i = 0; i < 130; i++) send(rnd_blk(), 1'b1);

    // Reset after 7 blocks of a row; partial row discarded, AM row first.
    n = 0;
    while (accq.size() != 7 && n < 40) begin
      send(rnd_blk(), 1'b0);
      n++;
    end
    check("partial_row_len", W'(accq.size()), W'(7));
    apply_reset();
    cyc(1'b0, '0, 1'b1, acc);
    chk_bit("post_reset_am_valid", ifa.o_valid, 1'b1);
    for (int i = 0; i < 40; i++) send(rnd_blk(), 1'b0);
    check("post_reset_rows", W'(rows_a), W'(3));

    // AM spacing at the full period on the narrow instance.
    en_a = 1'b0;
    ifa.i_valid = 1'b0;
    en_b = 1'b1;
    ifb.i_valid = 1'b1;
    rb = 0;
    n  = 0;
    while (rb < 2*PB + 1 && n < 70000) begin
      ifb.i_data = rnd_blk();
      @(posedge clk);
      @(negedge clk);
      if (ifb.o_valid === 1'b1) begin
        am = ((rb % PB) == 0);
        check("b_tags", W'({ifb.o_data[2*TB-1], ifb.o_data[TB-1]}), W'(am ? 2'b11 : 2'b00));
        if (am) check("b_am_row", W'(ifb.o_data), W'({1'b1, 66'd0, 1'b1, 66'd0}));
        rb++;
      end
      n++;
    end
    check("b_rows_seen", W'(rb), W'(2*PB + 1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
